// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter with burst locking that shares one memory port
module mem_port_arbiter #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 8,
  parameter int AddrWidth = 12
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_valid_i,
  output logic [NumReq-1:0]           req_ready_o,
  input  logic [AddrWidth-1:0]        req_addr_i    [NumReq],
  input  logic [NumReq-1:0]           req_we_i,
  input  logic signed [DataWidth-1:0] req_wr_data_i [NumReq],
  input  logic [NumReq-1:0]           req_last_i,
  output logic [NumReq-1:0]           rsp_valid_o,
  output logic signed [DataWidth-1:0] rsp_data_o,
  output logic [AddrWidth-1:0]        mem_addr_o,
  output logic                        mem_we_o,
  output logic signed [DataWidth-1:0] mem_wr_data_o,
  input  logic signed [DataWidth-1:0] mem_rd_data_i
);
  localparam int IdxW = $clog2(NumReq);
  typedef enum logic {IDLE, LOCKED} state_e;
  state_e                      state_q, state_d;
  logic [IdxW-1:0]             rr_q, rr_d, own_q, own_d, win, cand;
  logic                        found;
  logic [NumReq-1:0]           rsp_valid_q, rsp_valid_d;
  logic signed [DataWidth-1:0] rsp_data_q, rsp_data_d;

  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] x);
    return (int'(x) == NumReq - 1) ? '0 : x + 1'b1;
  endfunction

  // pick the winner: owner only while locked, else first valid at or above rr_q
  always_comb begin
    found = 1'b0;
    win   = own_q;
    cand  = '0;
    if (state_q == LOCKED) found = req_valid_i[own_q];
    else
      for (int i = 0; i < NumReq; i++) begin
        cand = IdxW'((int'(rr_q) + i) % NumReq);
        if (!found && req_valid_i[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
  end

  // grant and memory drive; outputs forced to 0 with no grant so nothing is written spuriously
  always_comb begin
    req_ready_o   = found ? (NumReq'(1) << win) : '0;
    mem_addr_o    = found ? req_addr_i[win] : '0;
    mem_we_o      = found ? req_we_i[win] : 1'b0;
    mem_wr_data_o = found ? req_wr_data_i[win] : '0;
  end

  // lock/pointer updates and one-cycle-late read response capture
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    own_d       = own_q;
    rsp_valid_d = (found && !req_we_i[win]) ? req_ready_o : '0;
    rsp_data_d  = (found && !req_we_i[win]) ? mem_rd_data_i : rsp_data_q;
    if (found && req_last_i[win]) begin
      state_d = IDLE;
      rr_d    = wrap_inc(win);
    end else if (found) begin
      state_d = LOCKED;
      own_d   = win;
    end
  end

  // state registers; reset aborts any lock
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      own_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      own_q       <= own_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter against a behavioural model
module tb_mem_port_arbiter;
  logic              clk, rst_ni;
  logic [3:0]        v, rdy, we, l, rsp_valid_o;
  logic [11:0]       a [4];
  logic signed [7:0] d [4];
  logic signed [7:0] rsp_data_o, mem_wr_data_o, mem_rd_data_i;
  logic [11:0]       mem_addr_o;
  logic              mem_we_o;

  mem_port_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(v), .req_ready_o(rdy),
    .req_addr_i(a), .req_we_i(we), .req_wr_data_i(d), .req_last_i(l),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_wr_data_o(mem_wr_data_o), .mem_rd_data_i(mem_rd_data_i)
  );

  typedef struct {int id; logic signed [7:0] data;} rsp_t;
  rsp_t              q[$];
  logic signed [7:0] env_mem [4096];
  logic signed [7:0] model_mem [4096];
  logic signed [7:0] held;
  int nvec, nfail, rr, own, dut_w;
  bit locked;
  int ord [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  assign mem_rd_data_i = env_mem[mem_addr_o];
  always @(posedge clk) if (rst_ni && mem_we_o) env_mem[mem_addr_o] <= mem_wr_data_o;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    v = 0; we = 0; l = 4'hF;
    for (int i = 0; i < 4; i++) begin a[i] = 0; d[i] = 0; end
  endtask

  task automatic step();
    int w;
    #3;
    w = -1;
    if (locked) begin
      if (v[own]) w = own;
    end else
      for (int k = 0; k < 4; k++) if (w < 0 && v[(rr + k) % 4]) w = (rr + k) % 4;
    dut_w = -1;
    for (int k = 0; k < 4; k++) if (rdy[k]) dut_w = k;
    chk("ready", 32'(rdy), w >= 0 ? 32'(1 << w) : 32'd0);
    chk("mem_addr", 32'(mem_addr_o), w >= 0 ? 32'(a[w]) : 32'd0);
    chk("mem_we", 32'(mem_we_o), w >= 0 ? 32'(we[w]) : 32'd0);
    chk("mem_wdata", 32'(mem_wr_data_o), w >= 0 ? 32'(d[w]) : 32'd0);
    if (w >= 0) begin
      if (!we[w]) q.push_back('{w, model_mem[a[w]]});
      else model_mem[a[w]] = d[w];
      if (l[w]) begin locked = 0; rr = (w + 1) % 4; end
      else begin locked = 1; own = w; end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_ni = 0;
    idle_inputs();
    q.delete();
    locked = 0; rr = 0; own = 0; held = 0;
    #2;
    chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
    chk("rst_rsp_data", 32'(rsp_data_o), 0);
    chk("rst_ready", 32'(rdy), 0);
    chk("rst_mem_addr", 32'(mem_addr_o), 0);
    chk("rst_mem_we", 32'(mem_we_o), 0);
    @(posedge clk); #1;
    rst_ni = 1;
  endtask

  // monitor: every response must match the head of the scoreboard, one cycle after its grant
  initial begin
    rsp_t e;
    forever begin
      @(posedge clk); #2;
      if (rst_ni) begin
        if (|rsp_valid_o) begin
          if (q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid_o), 0);
          else begin
            e = q.pop_front();
            chk("rsp_valid", 32'(rsp_valid_o), 32'(1 << e.id));
            chk("rsp_data", 32'(rsp_data_o), 32'(e.data));
            held = e.data;
          end
        end else begin
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("rsp_missing", 32'(rsp_valid_o), 32'(1 << e.id));
          end
          chk("rsp_hold", 32'(rsp_data_o), 32'(held));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    nvec = 0; nfail = 0;
    for (int i = 0; i < 4096; i++) begin
      env_mem[i] = 8'($urandom);
      model_mem[i] = env_mem[i];
    end
    idle_inputs();
    @(posedge clk); #1;
    do_reset();
    v = 4'hF; l = 4'hF;
    for (int i = 0; i < 4; i++) a[i] = 12'(i);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_order", 32'(dut_w), 32'(ord[i]));
    end
    idle_inputs();
    env_mem[16] = -8'sd5; model_mem[16] = -8'sd5;
    v = 4'b0100; a[2] = 12'h010;
    step();
    chk("rd_m5_valid", 32'(rsp_valid_o), 32'h4);
    chk("rd_m5_data", 32'(rsp_data_o), 32'(-8'sd5));
    idle_inputs();
    v = 4'b0010; a[1] = 12'h3FF; we[1] = 1; d[1] = 8'sh7F;
    step();
    idle_inputs();
    v = 4'b1000; a[3] = 12'h3FF;
    step();
    idle_inputs();
    step();
    chk("raw_data", 32'(rsp_data_o), 32'h7F);
    v = 4'b1011; l = 4'b1110;
    step(); chk("burst0", 32'(dut_w), 0);
    step(); chk("burst1", 32'(dut_w), 0);
    l = 4'hF;
    step(); chk("burst2", 32'(dut_w), 0);
    step(); chk("burst_next", 32'(dut_w), 1);
    idle_inputs();
    v = 4'b0001; l = 4'b1110; a[0] = 12'h055; a[2] = 12'h0AA;
    step(); chk("lock_own", 32'(dut_w), 0);
    v = 4'b0100;
    step(); chk("lock_gap0", 32'(dut_w), 32'(-1));
    step(); chk("lock_gap1", 32'(dut_w), 32'(-1));
    v = 4'b0101; l = 4'hF;
    step(); chk("lock_release", 32'(dut_w), 0);
    idle_inputs();
    v = 4'b1000; l = 4'b0111; a[3] = 12'h020;
    step(); chk("lock3", 32'(dut_w), 3);
    do_reset();
    v = 4'b1001; l = 4'hF;
    step(); chk("post_rst", 32'(dut_w), 0);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      v = 4'($urandom);
      we = 4'($urandom);
      for (int k = 0; k < 4; k++) begin
        a[k] = 12'($urandom_range(0, 15));
        d[k] = 8'($urandom);
        l[k] = ($urandom_range(0, 2) != 0);
      end
      step();
    end
    idle_inputs();
    locked = 0;
    step();
    step();
    #5;
    chk("drain", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
